// File: rtl/mdu_pkg.sv
// Shared MDU types: multiplier op encoding, arbiter FSM states and the latched op payload.
package mdu_pkg;

  localparam int unsigned MUL_XLEN = 32;

  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } mul_type_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  typedef struct packed {
    mul_type_e             op_type;
    logic [MUL_XLEN-1:0]   rs1;
    logic [MUL_XLEN-1:0]   rs2;
  } mul_op_t;

endpackage

// File: rtl/mul_req_arbiter_if.sv
// Request/response/multiplier bundle around the MDU multiplier arbiter.
interface mul_req_arbiter_if #(
  parameter int unsigned TAG_W = 4
);
  import mdu_pkg::*;

  logic [1:0]                   req_valid;
  logic [1:0]                   req_ready;
  mul_type_e [1:0]              req_type;
  logic [1:0][MUL_XLEN-1:0]     req_rs1;
  logic [1:0][MUL_XLEN-1:0]     req_rs2;
  logic [1:0][TAG_W-1:0]        req_tag;

  logic                         resp_valid;
  logic                         resp_ready;
  logic                         resp_id;
  logic [TAG_W-1:0]             resp_tag;
  logic [MUL_XLEN-1:0]          resp_data;

  logic                         kill;

  logic                         mul_in_valid;
  mul_type_e                    mul_type;
  logic [MUL_XLEN-1:0]          multiplicand;
  logic [MUL_XLEN-1:0]          multiplier;
  logic                         cpu_busy;
  logic [MUL_XLEN-1:0]          mul_out;
  logic                         mul_out_valid;
  logic                         mul_busy;

  modport slave (
    input  req_valid, req_type, req_rs1, req_rs2, req_tag,
    input  resp_ready, kill, mul_out, mul_out_valid, mul_busy,
    output req_ready, resp_valid, resp_id, resp_tag, resp_data,
    output mul_in_valid, mul_type, multiplicand, multiplier, cpu_busy
  );

  modport master (
    output req_valid, req_type, req_rs1, req_rs2, req_tag,
    output resp_ready, kill, mul_out, mul_out_valid, mul_busy,
    input  req_ready, resp_valid, resp_id, resp_tag, resp_data,
    input  mul_in_valid, mul_type, multiplicand, multiplier, cpu_busy
  );

endinterface

// File: rtl/mul_rr_arb2.sv
// Two-input round-robin grant: on a tie the requester that was not served last wins.
module mul_rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last,
  input  logic       en,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  always_comb begin
    gnt    = 2'b00;
    gnt_id = 1'b0;
    if (en) begin
      case (valid)
        2'b01: gnt = 2'b01;
        2'b10: begin
          gnt    = 2'b10;
          gnt_id = 1'b1;
        end
        2'b11: begin
          gnt_id = ~last;
          gnt    = last ? 2'b01 : 2'b10;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mul_req_arbiter.sv
// Shares one multiplier between two requesters: round-robin issue, held operands,
// one-entry response register with backpressure and flush.
module mul_req_arbiter
  import mdu_pkg::*;
#(
  parameter int unsigned TAG_W = 4
) (
  input logic              clk,
  input logic              rst_n,
  mul_req_arbiter_if.slave bus
);

  arb_state_e          state_q, state_d;
  logic                drop_q, drop_d;
  logic                rr_last_q;

  mul_op_t             op_q;
  logic [TAG_W-1:0]    op_tag_q;
  logic                op_id_q;

  logic                resp_valid_q;
  logic [MUL_XLEN-1:0] resp_data_q;
  logic                resp_id_q;
  logic [TAG_W-1:0]    resp_tag_q;

  logic                arb_en;
  logic [1:0]          gnt;
  logic                gnt_id;
  logic                hs;
  logic                capture;

  assign arb_en = (state_q == ST_IDLE) & ~bus.mul_busy & ~bus.kill;

  mul_rr_arb2 u_rr_arb2 (
    .valid  (bus.req_valid),
    .last   (rr_last_q),
    .en     (arb_en),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign hs = |(bus.req_valid & gnt);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
    end
  end

  // Next state; a kill that meets a finished result consumes it right away
  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (hs) state_d = ST_BUSY;
      end
      ST_BUSY: begin
        if (bus.kill) begin
          if (bus.mul_out_valid) begin
            state_d = ST_IDLE;
            drop_d  = 1'b0;
          end else begin
            drop_d  = 1'b1;
          end
        end else if (bus.mul_out_valid) begin
          if (drop_q) begin
            state_d = ST_IDLE;
            drop_d  = 1'b0;
          end else if (!resp_valid_q || bus.resp_ready) begin
            capture = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Op latch, round-robin pointer and response register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last_q    <= 1'b1;
      op_q         <= '0;
      op_tag_q     <= '0;
      op_id_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_id_q    <= 1'b0;
      resp_tag_q   <= '0;
    end else begin
      if (hs) begin
        rr_last_q <= gnt_id;
        op_q      <= '{op_type: bus.req_type[gnt_id],
                       rs1:     bus.req_rs1[gnt_id],
                       rs2:     bus.req_rs2[gnt_id]};
        op_tag_q  <= bus.req_tag[gnt_id];
        op_id_q   <= gnt_id;
      end
      if (bus.kill) begin
        resp_valid_q <= 1'b0;
      end else if (capture) begin
        resp_valid_q <= 1'b1;
        resp_data_q  <= bus.mul_out;
        resp_id_q    <= op_id_q;
        resp_tag_q   <= op_tag_q;
      end else if (bus.resp_ready) begin
        resp_valid_q <= 1'b0;
      end
    end
  end

  assign bus.req_ready    = gnt;
  assign bus.mul_in_valid = hs;
  assign bus.mul_type     = hs ? bus.req_type[gnt_id] : op_q.op_type;
  assign bus.multiplicand = hs ? bus.req_rs1[gnt_id]  : op_q.rs1;
  assign bus.multiplier   = hs ? bus.req_rs2[gnt_id]  : op_q.rs2;
  // Hold the multiplier in its done state until the response slot frees up
  assign bus.cpu_busy     = (state_q == ST_BUSY) & bus.mul_out_valid & resp_valid_q &
                            ~bus.resp_ready & ~bus.kill & ~drop_q;

  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_data    = resp_data_q;
  assign bus.resp_id      = resp_id_q;
  assign bus.resp_tag     = resp_tag_q;

endmodule

// File: tb/tb_mul_req_arbiter.sv
// Bench for mul_req_arbiter: behavioural 19-cycle multiplier plus scenario tasks
// checked against an arithmetic/round-robin reference model.
module tb_mul_req_arbiter;
  import mdu_pkg::*;

  localparam int unsigned TAG_W = 4;
  localparam int LAT = 19;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mul_req_arbiter_if #(.TAG_W(TAG_W)) bus ();

  mul_req_arbiter #(.TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_fail = 0;
  bit mdl_last = 1'b1;

  function automatic logic [31:0] ref_mul(input mul_type_e t, input logic [31:0] a, input logic [31:0] b);
    logic [65:0] ea, eb, p;
    logic sa, sb;
    sa = (t == MULH) || (t == MULHSU);
    sb = (t == MULH);
    ea = {{34{sa & a[31]}}, a};
    eb = {{34{sb & b[31]}}, b};
    p  = ea * eb;
    return (t == MUL) ? p[31:0] : p[63:32];
  endfunction

  // Environment multiplier: done 19 cycles after start, held while cpu_busy
  logic m_busy, m_done;
  int m_cnt;
  logic [31:0] m_a, m_b;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_cnt <= 0; m_a <= '0; m_b <= '0;
    end else if (m_done) begin
      if (!bus.cpu_busy) begin m_done <= 1'b0; m_busy <= 1'b0; end
    end else if (m_busy) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == 18) m_done <= 1'b1;
    end else if (bus.mul_in_valid) begin
      m_busy <= 1'b1; m_cnt <= 1; m_a <= bus.multiplicand; m_b <= bus.multiplier;
    end
  end
  assign bus.mul_busy      = m_busy;
  assign bus.mul_out_valid = m_done;
  assign bus.mul_out       = m_done ? ref_mul(bus.mul_type, m_a, m_b) : 32'h0;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input bit id, input mul_type_e t, input logic [31:0] a,
                         input logic [31:0] b, input logic [TAG_W-1:0] tg);
    bus.req_type[id] = t; bus.req_rs1[id] = a; bus.req_rs2[id] = b;
    bus.req_tag[id] = tg; bus.req_valid[id] = 1'b1;
  endtask

  task automatic wait_grant(output logic [1:0] g, output bit ok);
    ok = 1'b0; g = 2'b00;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (bus.req_ready != 2'b00) begin g = bus.req_ready; ok = 1'b1; return; end
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_resp(output int n, output bit ok);
    n = 0; ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus.resp_valid === 1'b1) begin ok = 1'b1; return; end
      tick(); n++;
    end
  endtask

  function automatic bit win(input logic [1:0] mask);
    return (mask == 2'b11) ? ~mdl_last : mask[1];
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; bus.req_valid = '0; bus.resp_ready = 1'b0; bus.kill = 1'b0;
    bus.req_type = '{MUL, MUL}; bus.req_rs1 = '0; bus.req_rs2 = '0; bus.req_tag = '0;
    tick(); tick(); rst_n = 1'b1; mdl_last = 1'b1; tick();
    n_chk++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid got=%b exp=0", bus.resp_valid); end
    n_chk++; if (bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL rst_req_ready got=%b exp=00", bus.req_ready); end
    n_chk++; if (bus.mul_in_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mul_in_valid got=%b exp=0", bus.mul_in_valid); end
    n_chk++; if (bus.cpu_busy !== 1'b0) begin n_fail++; $display("FAIL rst_cpu_busy got=%b exp=0", bus.cpu_busy); end
    n_chk++; if ({bus.multiplicand, bus.multiplier, bus.mul_type} !== 66'h0) begin n_fail++; $display("FAIL rst_mul_ops got=%h/%h/%0d exp=0", bus.multiplicand, bus.multiplier, bus.mul_type); end
    n_chk++; if ({bus.resp_data, bus.resp_id, bus.resp_tag} !== 37'h0) begin n_fail++; $display("FAIL rst_resp_fields got=%h/%b/%h exp=0", bus.resp_data, bus.resp_id, bus.resp_tag); end
  endtask

  task automatic test_alternation();
    logic [1:0] g; bit ok, w; int n;
    bus.resp_ready = 1'b1;
    set_req(1'b0, MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h1);
    set_req(1'b1, MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h2);
    for (int k = 0; k < 4; k++) begin
      wait_grant(g, ok);
      w = win(2'b11);
      n_chk++; if (!ok || g !== (w ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL alt_grant[%0d] got=%b exp=%b", k, g, w ? 2'b10 : 2'b01); end
      mdl_last = w;
      tick();
      wait_resp(n, ok);
      n_chk++; if (!ok || n != LAT) begin n_fail++; $display("FAIL alt_latency[%0d] got=%0d exp=%0d", k, n, LAT); end
      n_chk++; if (bus.resp_id !== w || bus.resp_data !== (w ? 32'hFFFF_FFFE : 32'h0) || bus.resp_tag !== (w ? 4'h2 : 4'h1)) begin
        n_fail++; $display("FAIL alt_resp[%0d] got=%b/%h/%h exp=%b/%h", k, bus.resp_id, bus.resp_data, bus.resp_tag, w, w ? 32'hFFFF_FFFE : 32'h0); end
    end
    bus.req_valid = '0;
    tick(); tick();
  endtask

  task automatic test_basic();
    int n; bit ok;
    bus.resp_ready = 1'b1;
    set_req(1'b0, MUL, 32'd7, 32'd6, 4'h3);
    #1;
    n_chk++; if (bus.req_ready !== 2'b01 || bus.mul_in_valid !== 1'b1) begin n_fail++; $display("FAIL basic_handshake got=%b/%b exp=01/1", bus.req_ready, bus.mul_in_valid); end
    n_chk++; if (bus.multiplicand !== 32'd7 || bus.multiplier !== 32'd6 || bus.mul_type !== MUL) begin n_fail++; $display("FAIL basic_comb_ops got=%h/%h exp=7/6", bus.multiplicand, bus.multiplier); end
    mdl_last = 1'b0;
    tick(); bus.req_valid = '0; #1;
    n_chk++; if (bus.mul_in_valid !== 1'b0) begin n_fail++; $display("FAIL basic_pulse got=%b exp=0", bus.mul_in_valid); end
    n_chk++; if (bus.multiplicand !== 32'd7 || bus.multiplier !== 32'd6) begin n_fail++; $display("FAIL basic_held_ops got=%h/%h exp=7/6", bus.multiplicand, bus.multiplier); end
    wait_resp(n, ok);
    n_chk++; if (!ok || n != LAT) begin n_fail++; $display("FAIL basic_latency got=%0d exp=%0d", n, LAT); end
    n_chk++; if (bus.resp_data !== 32'h2A || bus.resp_id !== 1'b0 || bus.resp_tag !== 4'h3) begin n_fail++; $display("FAIL basic_resp got=%h/%b/%h exp=2a/0/3", bus.resp_data, bus.resp_id, bus.resp_tag); end
    tick();
  endtask

  task automatic test_mulhsu();
    logic [1:0] g; bit ok; int n;
    logic [31:0] a [2];
    logic [31:0] b [2];
    logic [31:0] e [2];
    a[0] = 32'hFFFF_FFFF; b[0] = 32'hFFFF_FFFF; e[0] = 32'hFFFF_FFFF;
    a[1] = 32'h8000_0000; b[1] = 32'h0000_0003; e[1] = 32'hFFFF_FFFE;
    bus.resp_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      set_req(1'b1, MULHSU, a[k], b[k], 4'h9);
      wait_grant(g, ok);
      n_chk++; if (!ok || g !== 2'b10) begin n_fail++; $display("FAIL hsu_grant[%0d] got=%b exp=10", k, g); end
      mdl_last = 1'b1;
      tick(); bus.req_valid = '0; #1;
      n_chk++; if (bus.multiplicand !== a[k] || bus.multiplier !== b[k] || bus.mul_type !== MULHSU) begin
        n_fail++; $display("FAIL hsu_routing[%0d] got=%h/%h exp=%h/%h", k, bus.multiplicand, bus.multiplier, a[k], b[k]); end
      wait_resp(n, ok);
      n_chk++; if (!ok || bus.resp_data !== e[k] || bus.resp_id !== 1'b1) begin n_fail++; $display("FAIL hsu_resp[%0d] got=%h/%b exp=%h/1", k, bus.resp_data, bus.resp_id, e[k]); end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [1:0] g; bit ok, w1, w2; int n;
    logic [31:0] a0, b0, a1, b1, ea, eb, held;
    a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
    ea = ref_mul(MUL, a0, b0); eb = ref_mul(MULHU, a1, b1);
    bus.resp_ready = 1'b0;
    set_req(1'b0, MUL, a0, b0, 4'h4);
    set_req(1'b1, MULHU, a1, b1, 4'h5);
    w1 = win(2'b11); w2 = ~w1;
    wait_grant(g, ok);
    n_chk++; if (!ok || g !== (w1 ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL bp_grant1 got=%b exp_id=%b", g, w1); end
    mdl_last = w1;
    tick(); bus.req_valid[w1] = 1'b0;
    wait_resp(n, ok);
    wait_grant(g, ok);
    n_chk++; if (!ok || g !== (w2 ? 2'b10 : 2'b01) || bus.resp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_overlap_grant got=%b/%b exp_id=%b/1", g, bus.resp_valid, w2); end
    mdl_last = w2;
    tick(); bus.req_valid = '0;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin if (bus.cpu_busy === 1'b1) ok = 1'b1; else tick(); end
    n_chk++; if (!ok) begin n_fail++; $display("FAIL bp_cpu_busy got=0 exp=1"); end
    held = bus.mul_out;
    n_chk++; if (held !== (w2 ? eb : ea)) begin n_fail++; $display("FAIL bp_mul_out got=%h exp=%h", held, w2 ? eb : ea); end
    tick(); tick(); tick();
    n_chk++; if (bus.mul_out !== held || bus.cpu_busy !== 1'b1 || bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL bp_hold got=%h/%b/%b exp=%h/1/00", bus.mul_out, bus.cpu_busy, bus.req_ready, held); end
    n_chk++; if (bus.resp_data !== (w1 ? eb : ea) || bus.resp_id !== w1) begin n_fail++; $display("FAIL bp_first_pending got=%h/%b exp=%h/%b", bus.resp_data, bus.resp_id, w1 ? eb : ea, w1); end
    bus.resp_ready = 1'b1; #1;
    n_chk++; if (bus.cpu_busy !== 1'b0) begin n_fail++; $display("FAIL bp_release got=%b exp=0", bus.cpu_busy); end
    tick();
    n_chk++; if (bus.resp_valid !== 1'b1 || bus.resp_data !== (w2 ? eb : ea) || bus.resp_id !== w2) begin n_fail++; $display("FAIL bp_second got=%b/%h/%b exp=1/%h/%b", bus.resp_valid, bus.resp_data, bus.resp_id, w2 ? eb : ea, w2); end
    tick();
    n_chk++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_pop got=%b exp=0", bus.resp_valid); end
  endtask

  task automatic test_kill();
    logic [1:0] g; bit ok, seen; int n, c;
    logic [31:0] ba, bb;
    ba = $urandom; bb = $urandom;
    bus.resp_ready = 1'b0;
    set_req(1'b0, MUL, 32'd11, 32'd13, 4'hA);
    wait_grant(g, ok); mdl_last = 1'b0;
    tick(); bus.req_valid = '0;
    wait_resp(n, ok);
    set_req(1'b1, MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 4'hB);
    wait_grant(g, ok);
    n_chk++; if (!ok || g !== 2'b10) begin n_fail++; $display("FAIL kill_grant_a got=%b exp=10", g); end
    mdl_last = 1'b1;
    tick(); bus.req_valid = '0;
    set_req(1'b0, MULH, ba, bb, 4'hC);
    for (int i = 0; i < 7; i++) tick();
    bus.kill = 1'b1; #1;
    n_chk++; if (bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL kill_ready got=%b exp=00", bus.req_ready); end
    tick(); bus.kill = 1'b0;
    n_chk++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL kill_clear_resp got=%b exp=0", bus.resp_valid); end
    seen = 1'b0; ok = 1'b0; c = 9;
    for (int i = 0; i < 40 && !ok; i++) begin
      #1;
      if (bus.resp_valid === 1'b1) seen = 1'b1;
      if (bus.req_ready != 2'b00) ok = 1'b1; else begin @(posedge clk); #1; c++; end
    end
    n_chk++; if (seen) begin n_fail++; $display("FAIL kill_no_resp got=1 exp=0"); end
    n_chk++; if (!ok || c != 20 || bus.mul_busy !== 1'b0 || bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL kill_regrant got=cyc%0d/%b/%b exp=cyc20/0/01", c, bus.mul_busy, bus.req_ready); end
    mdl_last = 1'b0;
    bus.resp_ready = 1'b1;
    tick(); bus.req_valid = '0;
    wait_resp(n, ok);
    n_chk++; if (!ok || n != LAT || bus.resp_data !== ref_mul(MULH, ba, bb) || bus.resp_tag !== 4'hC) begin
      n_fail++; $display("FAIL kill_next_resp got=%0d/%h/%h exp=%0d/%h/c", n, bus.resp_data, bus.resp_tag, LAT, ref_mul(MULH, ba, bb)); end
    tick();
  endtask

  task automatic test_random();
    logic [1:0] g, mask; bit ok, w; int n;
    mul_type_e rt [2];
    logic [31:0] ra [2];
    logic [31:0] rb [2];
    logic [TAG_W-1:0] rtag [2];
    bus.resp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      mask = 2'($urandom_range(1, 3));
      for (int r = 0; r < 2; r++) begin
        rt[r] = mul_type_e'(2'($urandom_range(0, 3)));
        ra[r] = $urandom; rb[r] = $urandom; rtag[r] = TAG_W'($urandom);
        if (mask[r]) set_req(1'(r), rt[r], ra[r], rb[r], rtag[r]);
      end
      w = win(mask);
      wait_grant(g, ok);
      n_chk++; if (!ok || g !== (w ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL rnd_grant[%0d] mask=%b got=%b exp_id=%b", k, mask, g, w); end
      mdl_last = w;
      tick(); bus.req_valid = '0;
      wait_resp(n, ok);
      n_chk++; if (!ok || n != LAT || bus.resp_id !== w || bus.resp_tag !== rtag[w] || bus.resp_data !== ref_mul(rt[w], ra[w], rb[w])) begin
        n_fail++; $display("FAIL rnd_resp[%0d] got=%0d/%b/%h/%h exp=%0d/%b/%h/%h", k, n, bus.resp_id, bus.resp_tag, bus.resp_data, LAT, w, rtag[w], ref_mul(rt[w], ra[w], rb[w])); end
    end
    tick();
  endtask

  task automatic test_mid_reset();
    logic [1:0] g; bit ok; int n;
    bus.resp_ready = 1'b1;
    set_req(1'b1, MULHU, $urandom, $urandom, 4'h6);
    wait_grant(g, ok);
    tick(); bus.req_valid = '0;
    for (int i = 0; i < 9; i++) tick();
    rst_n = 1'b0; #1;
    n_chk++; if ({bus.req_ready, bus.mul_in_valid, bus.cpu_busy, bus.resp_valid} !== 5'b0) begin
      n_fail++; $display("FAIL mrst_ctrl got=%b/%b/%b/%b exp=0", bus.req_ready, bus.mul_in_valid, bus.cpu_busy, bus.resp_valid); end
    n_chk++; if ({bus.mul_type, bus.multiplicand, bus.multiplier, bus.resp_data, bus.resp_id, bus.resp_tag} !== 103'h0) begin
      n_fail++; $display("FAIL mrst_data got=%0d/%h/%h/%h exp=0", bus.mul_type, bus.multiplicand, bus.multiplier, bus.resp_data); end
    tick(); tick(); rst_n = 1'b1; mdl_last = 1'b1; tick();
    set_req(1'b0, MUL, 32'd3, 32'd5, 4'h7);
    wait_grant(g, ok);
    n_chk++; if (!ok || g !== 2'b01) begin n_fail++; $display("FAIL mrst_grant got=%b exp=01", g); end
    tick(); bus.req_valid = '0;
    wait_resp(n, ok);
    n_chk++; if (!ok || n != LAT || bus.resp_data !== 32'h0000_000F || bus.resp_tag !== 4'h7) begin
      n_fail++; $display("FAIL mrst_resp got=%0d/%h/%h exp=%0d/0000000f/7", n, bus.resp_data, bus.resp_tag, LAT); end
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alternation();
    test_basic();
    test_mulhsu();
    test_backpressure();
    test_kill();
    test_random();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
